// File: rtl/hub75_capture.sv
// HUB75 receive side: oversamples the panel lines and rebuilds each latched line into a parallel word.
// Optional build macro HUB75_CAP_OE_STATS_EN adds oe_cycles (clk_in cycles with OE asserted per line).
module hub75_capture #(
    parameter int PIXELS_PER_LINE = 64,
    parameter int ADDR_W          = 5
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         hub75_clk,
    input  logic                         hub75_latch,
    input  logic                         hub75_OE,
    input  logic [ADDR_W-1:0]            hub75_addr,
    input  logic [2:0]                   hub75_rgb0,
    input  logic [2:0]                   hub75_rgb1,
    output logic [3*PIXELS_PER_LINE-1:0] line_rgb0,
    output logic [3*PIXELS_PER_LINE-1:0] line_rgb1,
    output logic [ADDR_W-1:0]            line_addr,
    output logic                         line_count_err,
    output logic                         tvalid,
    input  logic                         tready,
`ifdef HUB75_CAP_OE_STATS_EN
    output logic [15:0]                  oe_cycles,
`endif
    output logic                         overrun
);

    localparam int SW    = 9 + ADDR_W;
    localparam int LW    = 3 * PIXELS_PER_LINE;
    localparam int IDX_W = $clog2(PIXELS_PER_LINE + 2);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(PIXELS_PER_LINE);
    localparam logic [IDX_W-1:0] IDX_OVF  = IDX_W'(PIXELS_PER_LINE + 1);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    // Sync vector layout: {clk, latch, OE, addr, rgb0, rgb1}
    logic [SW-1:0]       r_s1, r_s2, r_s3;
    logic                r_clk_rise, r_latch_rise;
    logic [LW-1:0]       r_buf0, r_buf1;
    logic [IDX_W-1:0]    r_idx;
    state_t              r_state;

    logic                w_oe;
    logic [ADDR_W-1:0]   w_addr;
    logic [2:0]          w_rgb0, w_rgb1;
    logic [LW-1:0]       w_buf0_nx, w_buf1_nx;
    logic [IDX_W-1:0]    w_idx_nx;
    logic                w_slot_free;
    state_t              w_state_nx;

    // r_s3 is both the edge-detect history and the data stage aligned with r_*_rise
    assign w_oe   = r_s3[6+ADDR_W];
    assign w_addr = r_s3[6 +: ADDR_W];
    assign w_rgb0 = r_s3[5:3];
    assign w_rgb1 = r_s3[2:0];

    always_comb begin
        w_state_nx  = r_state;
        w_slot_free = !tvalid || tready;
        case (r_state)
            ST_IDLE:  if (r_clk_rise && !r_latch_rise) w_state_nx = ST_SHIFT;
            ST_SHIFT: if (r_latch_rise) w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    // Shift is folded in ahead of the latch so a same-cycle pixel lands in the published word
    always_comb begin
        w_buf0_nx = r_buf0;
        w_buf1_nx = r_buf1;
        w_idx_nx  = r_idx;
        if (r_clk_rise) begin
            for (int i = 0; i < PIXELS_PER_LINE; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    w_buf0_nx[3*i +: 3] = w_rgb0;
                    w_buf1_nx[3*i +: 3] = w_rgb1;
                end
            end
            if (r_idx != IDX_OVF) w_idx_nx = r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_s1           <= '0;
            r_s2           <= '0;
            r_s3           <= '0;
            r_clk_rise     <= 1'b0;
            r_latch_rise   <= 1'b0;
            r_buf0         <= '0;
            r_buf1         <= '0;
            r_idx          <= '0;
            r_state        <= ST_IDLE;
            line_rgb0      <= '0;
            line_rgb1      <= '0;
            line_addr      <= '0;
            line_count_err <= 1'b0;
            tvalid         <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            r_s1         <= {hub75_clk, hub75_latch, hub75_OE, hub75_addr, hub75_rgb0, hub75_rgb1};
            r_s2         <= r_s1;
            r_s3         <= r_s2;
            r_clk_rise   <= r_s2[SW-1] & ~r_s3[SW-1];
            r_latch_rise <= r_s2[SW-2] & ~r_s3[SW-2];
            r_state      <= w_state_nx;
            if (r_latch_rise) begin
                if (w_slot_free) begin
                    line_rgb0      <= w_buf0_nx;
                    line_rgb1      <= w_buf1_nx;
                    line_addr      <= w_addr;
                    line_count_err <= (w_idx_nx != IDX_FULL);
                    tvalid         <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
                r_buf0 <= '0;
                r_buf1 <= '0;
                r_idx  <= '0;
            end else begin
                r_buf0 <= w_buf0_nx;
                r_buf1 <= w_buf1_nx;
                r_idx  <= w_idx_nx;
                if (tvalid && tready) tvalid <= 1'b0;
            end
        end
    end

`ifdef HUB75_CAP_OE_STATS_EN
    logic [15:0] r_oe_cnt;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_oe_cnt  <= '0;
            oe_cycles <= '0;
        end else if (r_latch_rise) begin
            r_oe_cnt <= '0;
            if (w_slot_free) oe_cycles <= r_oe_cnt;
        end else if (!w_oe && r_oe_cnt != 16'hFFFF) begin
            r_oe_cnt <= r_oe_cnt + 16'd1;
        end
    end
`else
    logic w_oe_unused;
    assign w_oe_unused = w_oe;
`endif

endmodule

// File: tb/tb_hub75_capture.sv
// Scoreboard bench for hub75_capture: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_hub75_capture;
    localparam int P  = 64;
    localparam int AW = 5;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b0;
    logic            hub75_clk = 1'b0, hub75_latch = 1'b0, hub75_OE = 1'b1;
    logic [AW-1:0]   hub75_addr = '0;
    logic [2:0]      hub75_rgb0 = '0, hub75_rgb1 = '0;
    logic            tready = 1'b0;
    logic [3*P-1:0]  line_rgb0, line_rgb1;
    logic [AW-1:0]   line_addr;
    logic            line_count_err, tvalid, overrun;
`ifdef HUB75_CAP_OE_STATS_EN
    logic [15:0]     oe_cycles;
`endif

    hub75_capture #(.PIXELS_PER_LINE(P), .ADDR_W(AW)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .hub75_clk(hub75_clk), .hub75_latch(hub75_latch), .hub75_OE(hub75_OE),
        .hub75_addr(hub75_addr), .hub75_rgb0(hub75_rgb0), .hub75_rgb1(hub75_rgb1),
        .line_rgb0(line_rgb0), .line_rgb1(line_rgb1), .line_addr(line_addr),
        .line_count_err(line_count_err), .tvalid(tvalid), .tready(tready),
`ifdef HUB75_CAP_OE_STATS_EN
        .oe_cycles(oe_cycles),
`endif
        .overrun(overrun)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3*P-1:0] r0;
        logic [3*P-1:0] r1;
        logic [AW-1:0]  addr;
        logic           err;
        int             oe_min;
        int             oe_max;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [2:0]  px0 [0:69];
    logic [2:0]  px1 [0:69];
    bit          rnd_ready = 1'b0;
    logic        tready_req = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: first min(n,P) pixels land in slots 0.., the rest stay zero; error unless exactly P pulses
    function automatic exp_t build_exp(input int n, input logic [AW-1:0] addr, input int omin, input int omax);
        exp_t e;
        e.r0 = '0;
        e.r1 = '0;
        for (int i = 0; i < n && i < P; i++) begin
            e.r0[3*i +: 3] = px0[i];
            e.r1[3*i +: 3] = px1[i];
        end
        e.addr   = addr;
        e.err    = (n != P);
        e.oe_min = omin;
        e.oe_max = omax;
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            tready = rnd_ready ? 1'($urandom_range(0, 1)) : tready_req;
        end
    end

    logic [3*P-1:0] h_r0, h_r1;
    logic [AW-1:0]  h_addr;
    logic           h_err;
    bit             h_held = 1'b0;

    always @(negedge clk_in) begin
        exp_t e;
        if (rst_in && h_held && tvalid)
            chk("hold_stable", {line_rgb0, line_rgb1, line_addr, line_count_err},
                {h_r0, h_r1, h_addr, h_err});
        if (rst_in && tvalid && tready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got addr %0d, expected no word", line_addr);
            end else begin
                e = sb.pop_front();
                chk("line_rgb0", line_rgb0, e.r0);
                chk("line_rgb1", line_rgb1, e.r1);
                chk("line_addr", line_addr, e.addr);
                chk("count_err", line_count_err, e.err);
`ifdef HUB75_CAP_OE_STATS_EN
                n_tests++;
                if (int'(oe_cycles) < e.oe_min || int'(oe_cycles) > e.oe_max) begin
                    n_fail++;
                    $display("FAIL oe_cycles: got %0d, expected %0d..%0d", oe_cycles, e.oe_min, e.oe_max);
                end
`endif
            end
        end
        h_held = rst_in && tvalid && !tready;
        h_r0   = line_rgb0;
        h_r1   = line_rgb1;
        h_addr = line_addr;
        h_err  = line_count_err;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic shift_px(input logic [2:0] a, input logic [2:0] b, input bit with_latch);
        hub75_rgb0 = a;
        hub75_rgb1 = b;
        cyc(4);
        hub75_clk = 1'b1;
        if (with_latch) hub75_latch = 1'b1;
        cyc(4);
        hub75_clk = 1'b0;
    endtask

    task automatic send_line(input int n, input logic [AW-1:0] addr, input bit push,
                             input bit same_cycle, input int oe_at, input int omin, input int omax);
        if (push) sb.push_back(build_exp(n, addr, omin, omax));
        hub75_addr = addr;
        for (int i = 0; i < n; i++) begin
            if (i == oe_at) begin
                hub75_OE = 1'b0;
                cyc(200);
                hub75_OE = 1'b1;
            end
            shift_px(px0[i], px1[i], same_cycle && (i == n - 1));
        end
        if (!same_cycle) begin
            hub75_latch = 1'b1;
            cyc(4);
        end
        hub75_latch = 1'b0;
        cyc(4);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 400) begin
            cyc(1);
            t++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending words, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic rand_px(input int n);
        for (int i = 0; i < n; i++) begin
            px0[i] = 3'($urandom);
            px1[i] = 3'($urandom);
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        int            n;

        // Reset with random activity on every input
        for (int i = 0; i < 8; i++) begin
            hub75_clk   = 1'($urandom);
            hub75_latch = 1'($urandom);
            hub75_OE    = 1'($urandom);
            hub75_addr  = AW'($urandom);
            hub75_rgb0  = 3'($urandom);
            hub75_rgb1  = 3'($urandom);
            tready_req  = 1'($urandom);
            cyc(1);
        end
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_err", line_count_err, 1'b0);
        chk("rst_addr", line_addr, '0);
        chk("rst_rgb0", line_rgb0, '0);
        chk("rst_rgb1", line_rgb1, '0);
        hub75_clk = 0; hub75_latch = 0; hub75_OE = 1; hub75_addr = '0;
        hub75_rgb0 = '0; hub75_rgb1 = '0; tready_req = 1'b1;
        cyc(2);
        rst_in = 1'b1;
        cyc(20);
        chk("idle_tvalid", tvalid, 1'b0);

        // Full line with fixed pattern
        for (int i = 0; i < P; i++) begin
            px0[i] = 3'(i % 8);
            px1[i] = 3'(7 - i % 8);
        end
        send_line(P, 5'd17, 1, 0, -1, 0, 65535);
        wait_drain();

        // Short and long lines
        rand_px(63);
        send_line(63, 5'd3, 1, 0, -1, 0, 65535);
        wait_drain();
        rand_px(70);
        send_line(70, 5'd30, 1, 0, -1, 0, 65535);
        wait_drain();

        // Final clk rise and latch rise together
        rand_px(P);
        px0[63] = 3'b101;
        px1[63] = 3'b101;
        send_line(P, 5'd9, 1, 1, -1, 0, 65535);
        wait_drain();

        // Random lines with random backpressure
        rnd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(62, 66);
            a = AW'($urandom);
            rand_px(n);
            send_line(n, a, 1, 0, -1, 0, 65535);
            wait_drain();
        end
        rnd_ready  = 1'b0;
        tready_req = 1'b0;
        cyc(2);

        // Backpressure: second line dropped while first is held
        rand_px(P);
        send_line(P, 5'd21, 1, 0, -1, 0, 65535);
        rand_px(P);
        send_line(P, 5'd22, 0, 0, -1, 0, 65535);
        cyc(5);
        chk("bp_overrun", overrun, 1'b1);
        chk("bp_tvalid", tvalid, 1'b1);
        chk("bp_addr", line_addr, 5'd21);
        tready_req = 1'b1;
        wait_drain();
        cyc(40);
        chk("bp_no_second", tvalid, 1'b0);

        // Mid-line reset with OE asserted before it
        rand_px(10);
        hub75_addr = 5'd4;
        hub75_OE = 1'b0;
        for (int i = 0; i < 10; i++) shift_px(px0[i], px1[i], 0);
        hub75_OE = 1'b1;
        rst_in = 1'b0;
        cyc(3);
        rst_in = 1'b1;
        cyc(5);
        chk("mrst_overrun", overrun, 1'b0);
        chk("mrst_tvalid", tvalid, 1'b0);
        rand_px(P);
        send_line(P, 5'd12, 1, 0, -1, 0, 4);
        wait_drain();

        // OE held low for 200 cycles inside a line
        rand_px(P);
        send_line(P, 5'd25, 1, 0, 10, 200, 200);
        wait_drain();

        cyc(20);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
